seg_mmio_regs: RTL
==================

# seg_mmio_regs

Memory-mapped register bank between the CPU data bus and the seven-segment display driver. It captures CPU stores to the display address window and holds the 32-bit hex value the display driver scans out. It adds a per-digit enable mask and a programmable blink generator, and it supports CPU readback of every register.

## Interface

**Parameters**
- `BLINK_DIV_RST`, 16'hFFFF: reset value of the BLINK_DIV register.

**Ports**
- `clk` input 1: system clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `SegCtrl` input 1: chip select from the address decoder. High when the CPU address falls in the display window.
- `io_write` input 1: CPU store strobe. Sampled on a `clk` edge when `SegCtrl` is high.
- `io_read` input 1: CPU load strobe.
- `addr` input 4: byte offset within the window. Valid offsets are 0x0, 0x4, 0x8 and 0xC.
- `wdata` input 32: store data.
- `rdata` output 32: load data. Combinational.
- `write_data` output 32: displayed hex value. Feeds the display driver.
- `digit_en` output 8: per-digit enable. Bit 7 is the leftmost digit (`write_data[31:28]`).

## Operation

**Registers**
- **DATA (0x0, R/W):** 32 bits, reset 0. Drives `write_data` directly.
- **CTRL (0x4, R/W):**
  - bit0 `blink_en`, reset 0.
  - bits[15:8] `mask`, reset 8'hFF.
  - All other bits read 0, and writes to them are ignored.
- **BLINK_DIV (0x8, R/W):** bits[15:0], reset `BLINK_DIV_RST`. Upper bits read 0.
- **WCOUNT (0xC, RO):** 16-bit count of accepted writes to DATA, reset 0. Saturates at 16'hFFFF. A write to 0xC is ignored.

**Write acceptance**
- A write is accepted when `SegCtrl & io_write`, `addr[1:0]==0` and `addr` is one of 0x0, 0x4 or 0x8.
- Any other write is dropped with no state change.

**Readback**
- `rdata` shows the selected register when `SegCtrl & io_read` and `addr[1:0]==0`. Otherwise `rdata = 0`.

**Blink generator**
- 24-bit counter `cnt` and 1-bit `phase`.
- **`blink_en=0`:** `cnt` is held at 0 and `phase` at 0.
- **`blink_en=1`:** `cnt` increments every cycle.
  - When `cnt == {BLINK_DIV, 8'hFF}`, `cnt` wraps to 0 and `phase` toggles on that same edge.
  - Half-period is therefore (BLINK_DIV+1)·256 cycles.
- An accepted write to BLINK_DIV, or to CTRL with `wdata[0]` = 1, clears `cnt` and `phase` on the same edge.
  - This restarts the blink from the visible half.
- **Output:** `digit_en = phase ? 8'h00 : mask`.

**Simultaneous events**
- **Read and write to the same offset in one cycle:** `rdata` returns the pre-write value, because it is combinational from the current registers.
- **Write to DATA while WCOUNT = 16'hFFFF:** DATA updates and WCOUNT stays at 16'hFFFF.
- **Reset:** `rst` has priority over every write and counter update.

## Timing

- **Reset outputs:** after the first rising edge with `rst=1`:
  - `write_data = 0`
  - `digit_en = 8'hFF`
  - `rdata = 0` when no read is selected
  - `cnt = 0`, `phase = 0`
- **Write latency:** a write accepted at edge N is visible on `write_data`, `digit_en` and `rdata` immediately after edge N. That is one cycle after the strobe is presented; there is no further pipeline.
- **Read latency:** zero cycles, combinational from `addr` and the select.
- **Blink toggle:** with `blink_en` first set at edge N, the first `phase` toggle occurs at edge N + (BLINK_DIV+1)·256.
- **Reset mid-blink:** `phase` clears on the reset edge, so `digit_en` returns to 8'hFF next cycle. `blink_en` clears, so the blink stays off until reprogrammed.
- **Register stability:** all outputs except `rdata` come straight from registers and are glitch-free for the driver's scan mux.

## Test plan

1. **Reset defaults:** assert `rst` for 2 cycles. Expect:
   - `write_data = 0`, `digit_en = 8'hFF`.
   - Reading 0x4 returns 32'h0000FF00; reading 0x8 returns 32'h0000FFFF.
2. **Data write and readback:**
   - Write 0x0 = 32'h1234ABCD. Expect `write_data = 32'h1234ABCD` the cycle after the strobe; reading 0x0 returns the same value; reading 0xC returns 1.
   - A write to 0x2 (misaligned) or 0xC changes nothing.
3. **Blink:** write BLINK_DIV = 0, then CTRL = 32'h0000F001. Expect:
   - `digit_en = 8'hF0` for 256 cycles, then 8'h00 for 256 cycles, then 8'hF0 again.
   - Writing CTRL = 32'h0000F000 freezes `digit_en` at 8'hF0.
4. **Same-cycle read/write:** hold DATA = 5 and, in one cycle, read and write 0x0 = 9. Expect `rdata = 5` in that cycle and `rdata = 9` on the next read.
5. **WCOUNT saturation:** perform 65,537 DATA writes. Expect WCOUNT = 16'hFFFF and DATA equal to the last written value.
6. **Reset mid-blink:** assert `rst` during the `phase = 1` half of test 3. Expect, the next cycle, `digit_en = 8'hFF`, `cnt = 0` and CTRL back at its reset value.

Source files
------------

// File: rtl/seg_mmio_regs.sv
// CPU-facing register bank for the seven-segment display: DATA, CTRL, BLINK_DIV, WCOUNT.
// Latency: writes visible one edge after the strobe; reads are combinational (zero cycles).
// Backpressure: none; every access completes in the cycle it is presented.
module seg_mmio_regs #(
  parameter logic [15:0] BLINK_DIV_RST = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SegCtrl,
  input  logic        io_write,
  input  logic        io_read,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] write_data,
  output logic [7:0]  digit_en
);

  logic [31:0] r_data;
  logic        r_blink_en;
  logic [7:0]  r_mask;
  logic [15:0] r_blink_div;
  logic [15:0] r_wcount;
  logic [23:0] r_cnt;
  logic        r_phase;

  logic w_aligned;
  logic w_wr_ok;
  logic w_wr_data;
  logic w_wr_ctrl;
  logic w_wr_div;
  logic w_rd_sel;
  logic w_blink_restart;
  logic w_cnt_wrap;

  // Offset 0xC is read-only, so it is excluded from write acceptance.
  assign w_aligned       = (addr[1:0] == 2'b00);
  assign w_wr_ok         = SegCtrl & io_write & w_aligned & (addr[3:2] != 2'b11);
  assign w_wr_data       = w_wr_ok & (addr[3:2] == 2'b00);
  assign w_wr_ctrl       = w_wr_ok & (addr[3:2] == 2'b01);
  assign w_wr_div        = w_wr_ok & (addr[3:2] == 2'b10);
  assign w_rd_sel        = SegCtrl & io_read & w_aligned;

  // Reprogramming the divider or (re)enabling blink restarts on the visible half.
  assign w_blink_restart = w_wr_div | (w_wr_ctrl & wdata[0]);
  assign w_cnt_wrap      = (r_cnt == {r_blink_div, 8'hFF});

  // CPU-visible registers and the saturating DATA write counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= 32'h0;
      r_blink_en  <= 1'b0;
      r_mask      <= 8'hFF;
      r_blink_div <= BLINK_DIV_RST;
      r_wcount    <= 16'h0;
    end else begin
      if (w_wr_data) begin
        r_data <= wdata;
        if (r_wcount != 16'hFFFF) begin
          r_wcount <= r_wcount + 16'd1;
        end
      end
      if (w_wr_ctrl) begin
        r_blink_en <= wdata[0];
        r_mask     <= wdata[15:8];
      end
      if (w_wr_div) begin
        r_blink_div <= wdata[15:0];
      end
    end
  end

  // Blink divider: half-period of (BLINK_DIV+1)*256 cycles, parked at zero when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 24'h0;
      r_phase <= 1'b0;
    end else if (w_blink_restart || !r_blink_en) begin
      r_cnt   <= 24'h0;
      r_phase <= 1'b0;
    end else if (w_cnt_wrap) begin
      r_cnt   <= 24'h0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 24'd1;
    end
  end

  assign write_data = r_data;
  assign digit_en   = r_phase ? 8'h00 : r_mask;

  // Readback mux; returns the pre-write value when a write to the same offset is in flight.
  always_comb begin
    rdata = 32'h0;
    if (w_rd_sel) begin
      case (addr[3:2])
        2'b00:   rdata = r_data;
        2'b01:   rdata = {16'h0, r_mask, 7'h0, r_blink_en};
        2'b10:   rdata = {16'h0, r_blink_div};
        default: rdata = {16'h0, r_wcount};
      endcase
    end
  end

endmodule
